// File: rtl/he_lut_remap.sv
// Histogram-equalization table consumer: captures a streamed 256-entry
// table into a local LUT, then remaps one frame of pixels through it.
module he_lut_remap #(
  parameter int PIX_W      = 8,
  parameter int NUM_PIXELS = 290400,
  parameter int CNT_W      = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tbl_start,
  input  logic [PIX_W-1:0] tbl_data,
  input  logic             pix_in_valid,
  input  logic [PIX_W-1:0] pix_in,
  output logic             table_ready,
  output logic             pix_out_valid,
  output logic [PIX_W-1:0] pix_out,
  output logic             frame_done
);

  localparam int DEPTH = 1 << PIX_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAP
  } state_t;

  state_t           state_q, state_d;
  logic [PIX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PIX_W-1:0] pix_out_q, pix_out_d;
  logic             vld_q, vld_d;
  logic             fd_q, fd_d;
  logic             rdy_q, rdy_d;

  logic [PIX_W-1:0] lut_q [DEPTH];
  logic             lut_we;
  logic [PIX_W-1:0] lut_waddr;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    pix_out_d = pix_out_q;
    vld_d     = 1'b0;
    fd_d      = 1'b0;
    lut_we    = 1'b0;
    lut_waddr = idx_q;
    unique case (state_q)
      IDLE: begin
        if (tbl_start) begin
          lut_we    = 1'b1;
          lut_waddr = '0;
          idx_d     = PIX_W'(1);
          state_d   = LOAD;
        end
      end
      LOAD: begin
        lut_we = 1'b1;
        idx_d  = idx_q + PIX_W'(1);
        if (idx_q == '1) begin
          state_d = MAP;
        end
      end
      MAP: begin
        if (pix_in_valid) begin
          pix_out_d = lut_q[pix_in];
          vld_d     = 1'b1;
          // Final pixel closes the frame; next frame needs a fresh table.
          if (cnt_q == LAST) begin
            fd_d    = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == MAP);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      pix_out_q <= '0;
      vld_q     <= 1'b0;
      fd_q      <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pix_out_q <= pix_out_d;
      vld_q     <= vld_d;
      fd_q      <= fd_d;
      rdy_q     <= rdy_d;
    end
  end

  // Table storage survives reset; table_ready gates any stale use.
  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_q[lut_waddr] <= tbl_data;
    end
  end

  assign table_ready   = rdy_q;
  assign pix_out_valid = vld_q;
  assign pix_out       = pix_out_q;
  assign frame_done    = fd_q;

endmodule

// File: tb/tb_he_lut_remap.sv
// Directed + random bench for he_lut_remap with a cycle-stamped
// expected-output queue and a small 4-pixel frame.
module tb_he_lut_remap;

  localparam int NP = 4;

  logic       clk;
  logic       reset;
  logic       tbl_start;
  logic [7:0] tbl_data;
  logic       pix_in_valid;
  logic [7:0] pix_in;
  logic       table_ready;
  logic       pix_out_valid;
  logic [7:0] pix_out;
  logic       frame_done;

  he_lut_remap #(
    .PIX_W(8),
    .NUM_PIXELS(NP),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .tbl_start(tbl_start),
    .tbl_data(tbl_data),
    .pix_in_valid(pix_in_valid),
    .pix_in(pix_in),
    .table_ready(table_ready),
    .pix_out_valid(pix_out_valid),
    .pix_out(pix_out),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic       fd;
    logic [7:0] d;
  } exp_t;

  exp_t       q[$];
  logic [7:0] tbl[256];
  logic [7:0] mdl[256];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fcnt = 0;
  int frames_exp = 0;
  int fd_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output side of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic ev;
    cyc++;
    ev = (q.size() > 0) && (q[0].cyc == cyc);
    chk("out_valid", 32'(pix_out_valid), 32'(ev));
    if (ev) begin
      e = q.pop_front();
      chk("out_data", 32'(pix_out), 32'(e.d));
      chk("out_fd", 32'(frame_done), 32'(e.fd));
    end else begin
      chk("fd_idle", 32'(frame_done), 32'(1'b0));
    end
    if (frame_done) fd_seen++;
  end

  task automatic drive(input logic st, input logic [7:0] d,
                       input logic v, input logic [7:0] p,
                       input logic acc);
    exp_t e;
    @(negedge clk);
    #1;
    tbl_start    = st;
    tbl_data     = d;
    pix_in_valid = v;
    pix_in       = p;
    if (acc && v) begin
      fcnt++;
      e.cyc = cyc + 1;
      e.fd  = (fcnt == NP);
      e.d   = mdl[p];
      q.push_back(e);
      if (fcnt == NP) begin
        fcnt = 0;
        frames_exp++;
      end
    end
  endtask

  task automatic pixel(input logic [7:0] p);
    drive(1'b0, 8'($urandom), 1'b1, p, 1'b1);
  endtask

  task automatic bubble();
    drive(1'b0, 8'($urandom), 1'b0, 8'($urandom), 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 8'($urandom), 1'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic load(input logic fd_exp);
    for (int k = 0; k < 256; k++) begin
      drive(k == 0 ? 1'b1 : 1'($urandom), tbl[k],
            1'($urandom), 8'($urandom), 1'b0);
      mdl[k] = tbl[k];
      if (k == 0) begin
        chk("ld_fd", 32'(frame_done), 32'(fd_exp));
        chk("ld_rdy_T", 32'(table_ready), 32'(1'b0));
      end
      if (k == 255) chk("ld_rdy_T255", 32'(table_ready), 32'(1'b0));
    end
  endtask

  initial begin
    reset = 1'b0;
    tbl_start = 1'b0;
    tbl_data = '0;
    pix_in_valid = 1'b0;
    pix_in = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 32'(table_ready), 32'(1'b0));
    chk("rst_valid", 32'(pix_out_valid), 32'(1'b0));
    chk("rst_pix", 32'(pix_out), 32'(8'h00));
    reset = 1'b1;
    idle(2);

    // Identity table
    for (int k = 0; k < 256; k++) tbl[k] = 8'(k);
    load(1'b0);
    pixel(8'h00);
    chk("id_ready_T256", 32'(table_ready), 32'(1'b1));
    pixel(8'h7F);
    pixel(8'hFF);
    pixel(8'h33);
    drive(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    chk("id_fd", 32'(frame_done), 32'(1'b1));
    chk("id_rdy_fall", 32'(table_ready), 32'(1'b0));
    drive(1'b0, 8'h00, 1'b1, 8'h66, 1'b0);
    chk("idle_novalid", 32'(pix_out_valid), 32'(1'b0));

    // Inverted table with a bubble
    for (int k = 0; k < 256; k++) tbl[k] = 8'(255 - k);
    load(1'b0);
    pixel(8'h10);
    bubble();
    pixel(8'h00);
    chk("inv_bubble_v", 32'(pix_out_valid), 32'(1'b0));
    chk("inv_bubble_hold", 32'(pix_out), 32'(8'hEF));
    pixel(8'hFF);
    pixel(8'h80);

    // Back-to-back: new load starts in the frame_done cycle
    for (int k = 0; k < 256; k++) tbl[k] = 8'(k) ^ 8'h0F;
    load(1'b1);
    pixel(8'h01);
    pixel(8'hF0);
    pixel(8'h0F);
    pixel(8'h00);
    idle(1);
    chk("b2b_fd", 32'(frame_done), 32'(1'b1));

    // Reset in the middle of a load
    for (int k = 0; k <= 100; k++)
      drive(k == 0, 8'($urandom), 1'b1, 8'($urandom), 1'b0);
    chk("pre_rst_pix", 32'(pix_out), 32'(8'h0F));
    #2;
    reset = 1'b0;
    #1;
    chk("arst_pix", 32'(pix_out), 32'(8'h00));
    chk("arst_ready", 32'(table_ready), 32'(1'b0));
    chk("arst_valid", 32'(pix_out_valid), 32'(1'b0));
    fcnt = 0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    idle(1);
    for (int k = 0; k < 256; k++) tbl[k] = 8'hAA;
    load(1'b0);
    for (int i = 0; i < NP; i++) pixel(8'($urandom));
    idle(2);

    // Random tables, pixels and bubbles
    for (int f = 0; f < 10; f++) begin
      for (int k = 0; k < 256; k++) tbl[k] = 8'($urandom);
      load(1'b0);
      for (int i = 0; i < NP; ) begin
        if ($urandom_range(3) == 0) bubble();
        else begin
          pixel(8'($urandom));
          i++;
        end
      end
      idle(int'($urandom_range(1, 3)));
    end

    idle(4);
    chk("q_drained", 32'(q.size()), 32'(0));
    chk("fd_count", 32'(fd_seen), 32'(frames_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
